keypad_code_sequencer: RTL
==========================

Name: keypad_code_sequencer

Overview:
- Controller that sits after input_encoder and sequences the keypad's BCD output into a multi-digit access code.
- Debounces and edge-qualifies each key press and collects NUM_DIGITS digits.
- Compares the collected digits against a stored code and drives unlock, fail and lockout status.
- The stored code can be reprogrammed while unlocked. Status outputs feed the demux/T-FF counter stage as mode/clock-enable sources.

Parameters:
- NUM_DIGITS, 4: digits per code; code width is 4*NUM_DIGITS bits.
- RESET_CODE, 16'h1234: code loaded on reset, BCD. First-entered digit is in the MSB nibble.
- DEBOUNCE, 3: consecutive cycles key_valid must be high before a press is accepted.
- UNLOCK_CYCLES, 8: cycles the unlocked output stays high.
- MAX_FAILS, 3: consecutive wrong codes that trigger lockout.
- LOCKOUT_CYCLES, 16: cycles spent in lockout.
- TIMEOUT, 32: idle cycles allowed between digits in ENTRY/PROG before the entry is abandoned.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- key_code  in  4  BCD digit from input_encoder (out[3:0]).
- key_valid  in  1  key-pressed flag from input_encoder (out[4]).
- prog_en  in  1  request to reprogram the code; sampled only in UNLOCK.
- unlocked  out  1  high while in UNLOCK or PROG.
- lockout  out  1  high while in LOCKOUT.
- fail_pulse  out  1  one-cycle pulse on a wrong code.
- prog_done  out  1  one-cycle pulse when a new code is stored.
- digit_count  out  3  digits collected in the current entry.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; code register=RESET_CODE; digit buffer=0.
  - All counters and the fail count are 0; all outputs are 0.
  - Reset asserted mid-entry or mid-lockout aborts immediately, with the same result.
- Key acceptance:
  - A stability counter increments while key_valid=1, saturating at DEBOUNCE, and clears when key_valid=0.
  - An accept strobe fires in the cycle the counter reaches DEBOUNCE. Exactly one accept per press; key_valid must drop for at least 1 cycle before the next accept.
  - Presses shorter than DEBOUNCE cycles are ignored.
  - key_code is sampled in the accept cycle. Codes above 9 are discarded: no digit is stored and the timeout is not restarted.
  - Accepts in CHECK, UNLOCK, FAIL or LOCKOUT are discarded.
- Digit buffer: on each valid accept, buffer <= {buffer shifted left 4, key_code} and digit_count increments.
- States:
  - IDLE: a valid accept stores the digit and moves to ENTRY with digit_count=1. If NUM_DIGITS=1, go directly to CHECK.
  - ENTRY:
    - A valid accept stores the digit and restarts the timeout counter.
    - When the NUM_DIGITS-th digit is stored, go to CHECK on the next cycle.
    - If no valid accept arrives for TIMEOUT cycles, go to IDLE, clear the buffer and digit_count, and do not count a fail.
  - CHECK (1 cycle):
    - buffer == code: go to UNLOCK and clear the fail count.
    - Otherwise: go to FAIL.
    - In both cases clear the buffer and digit_count.
  - UNLOCK:
    - unlocked=1 for exactly UNLOCK_CYCLES cycles, then go to IDLE.
    - If prog_en=1 in any UNLOCK cycle, go to PROG on the next cycle.
  - PROG:
    - unlocked=1; collect NUM_DIGITS digits using the ENTRY rules.
    - On the final digit, write the code register and pulse prog_done, then go to IDLE.
    - On timeout, go to IDLE with the code unchanged.
  - FAIL (1 cycle):
    - Pulse fail_pulse and increment the fail count.
    - If the incremented count equals MAX_FAILS, go to LOCKOUT; otherwise go to IDLE.
  - LOCKOUT: lockout=1 for LOCKOUT_CYCLES cycles, then clear the fail count and go to IDLE.
- Latency: if the final digit is accepted in cycle k, CHECK occurs in cycle k+1 and unlocked (or fail_pulse) is high from cycle k+2.
- Simultaneity: key acceptance is evaluated before the state transition in the same cycle. A key held high across a state change is not re-accepted.

Test Plan:
- Reset: assert reset for 2 cycles → all outputs 0, digit_count=0, busy=0.
- Correct code with defaults:
  - Stimulus: press 1,2,3,4, each with key_valid high for 5 cycles and low for 3.
  - Required: accept occurs in the 3rd high cycle of each press; unlocked rises 2 cycles after the 4th accept and stays high for 8 cycles; digit_count reads 1,2,3,4 and then 0.
- Debounce and out-of-range codes:
  - A 2-cycle press of digit 5 → ignored, digit_count unchanged.
  - A key_code=4'hA press → ignored.
  - Holding digit 7 for 20 cycles → exactly one digit stored.
- Lockout: enter 9,9,9,9 three times → fail_pulse fires 3 times; after the 3rd, lockout=1 for 16 cycles; a correct 1234 entered during lockout is ignored; after lockout, 1234 unlocks.
- Reprogramming and timeout:
  - Unlock, pulse prog_en, enter 5,6,7,8 → prog_done pulses.
  - Then 1234 → fail; 5678 → unlocked.
  - Enter 2 digits and idle 32 cycles → back to IDLE, no fail_pulse.
- Reset mid-entry: assert reset after 3 digits → IDLE; code reverts to 16'h1234.

Source files
------------

// File: rtl/keypad_code_sequencer.sv
// Access-code sequencer: debounces keypad BCD presses, collects a multi-digit code,
// compares it with a stored code and drives unlock / fail / lockout status.
module keypad_code_sequencer #(
    parameter int                      NUM_DIGITS     = 4,
    parameter logic [4*NUM_DIGITS-1:0] RESET_CODE     = 16'h1234,
    parameter int                      DEBOUNCE       = 3,
    parameter int                      UNLOCK_CYCLES  = 8,
    parameter int                      MAX_FAILS      = 3,
    parameter int                      LOCKOUT_CYCLES = 16,
    parameter int                      TIMEOUT        = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic       prog_en,
    output logic       unlocked,
    output logic       lockout,
    output logic       fail_pulse,
    output logic       prog_done,
    output logic [2:0] digit_count,
    output logic       busy
);

    localparam int CW   = 4 * NUM_DIGITS;
    localparam int SW   = $clog2(DEBOUNCE + 1);
    localparam int FW   = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (TIMEOUT > UNLOCK_CYCLES)
                        ? ((TIMEOUT > LOCKOUT_CYCLES) ? TIMEOUT : LOCKOUT_CYCLES)
                        : ((UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [SW-1:0] STAB_MAX   = SW'(DEBOUNCE);
    localparam logic [SW-1:0] STAB_LAST  = SW'(DEBOUNCE - 1);
    localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAILS - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] UNL_LAST   = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_UNLOCK,
        S_PROG,
        S_FAIL,
        S_LOCKOUT
    } state_t;

    state_t        state;
    logic [SW-1:0] stab_cnt;
    logic [CW-1:0] code_q;
    logic [CW-1:0] digit_buf;
    logic [CW-1:0] next_buf;
    logic [TW-1:0] tmr;
    logic [FW-1:0] fail_cnt;
    logic          accept;
    logic          digit_ok;
    logic          last_digit;

    // The counter saturates, so a held key yields exactly one accept until key_valid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            stab_cnt <= '0;
        end else if (!key_valid) begin
            stab_cnt <= '0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + SW'(1);
        end
    end

    assign accept     = key_valid && (stab_cnt == STAB_LAST);
    assign digit_ok   = accept && (key_code <= 4'd9);
    assign last_digit = (digit_count == LAST_DIGIT);
    assign next_buf   = (digit_buf << 4) | CW'(key_code);

    // NOTE: sequential state uses non-blocking assignments only; every output is a register
    // updated alongside the state, so consumers downstream see glitch-free levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            code_q      <= RESET_CODE;
            digit_buf   <= '0;
            digit_count <= '0;
            tmr         <= '0;
            fail_cnt    <= '0;
            unlocked    <= 1'b0;
            lockout     <= 1'b0;
            fail_pulse  <= 1'b0;
            prog_done   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            fail_pulse <= 1'b0;
            prog_done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (digit_ok) begin
                        digit_buf   <= next_buf;
                        digit_count <= digit_count + 3'd1;
                        tmr         <= '0;
                        busy        <= 1'b1;
                        state       <= last_digit ? S_CHECK : S_ENTRY;
                    end
                end

                S_ENTRY, S_PROG: begin
                    if (digit_ok) begin
                        tmr <= '0;
                        if (last_digit && state == S_PROG) begin
                            code_q      <= next_buf;
                            prog_done   <= 1'b1;
                            digit_buf   <= '0;
                            digit_count <= '0;
                            unlocked    <= 1'b0;
                            busy        <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            // The full code stays in the buffer for the CHECK cycle.
                            digit_buf   <= next_buf;
                            digit_count <= digit_count + 3'd1;
                            if (last_digit) begin
                                state <= S_CHECK;
                            end
                        end
                    end else if (tmr == TMO_LAST) begin
                        tmr         <= '0;
                        digit_buf   <= '0;
                        digit_count <= '0;
                        unlocked    <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end

                S_CHECK: begin
                    digit_buf   <= '0;
                    digit_count <= '0;
                    tmr         <= '0;
                    if (digit_buf == code_q) begin
                        fail_cnt <= '0;
                        unlocked <= 1'b1;
                        state    <= S_UNLOCK;
                    end else begin
                        fail_pulse <= 1'b1;
                        state      <= S_FAIL;
                    end
                end

                S_UNLOCK: begin
                    if (prog_en) begin
                        tmr   <= '0;
                        state <= S_PROG;
                    end else if (tmr == UNL_LAST) begin
                        tmr      <= '0;
                        unlocked <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end

                S_FAIL: begin
                    fail_cnt <= fail_cnt + FW'(1);
                    tmr      <= '0;
                    if (fail_cnt == FAIL_LAST) begin
                        lockout <= 1'b1;
                        state   <= S_LOCKOUT;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                S_LOCKOUT: begin
                    if (tmr == LOCK_LAST) begin
                        tmr      <= '0;
                        fail_cnt <= '0;
                        lockout  <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end

                default: begin
                    unlocked <= 1'b0;
                    lockout  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
